mult_sequencer: RTL
===================

Name: mult_sequencer

Overview:
- Control sequencer for the 16b multi-cycle shift-add multiplier datapath (5-entry 32b register file, adder, logical shifter, partial-product generator on a shared Z bus).
- Sits directly upstream of the datapath:
  - accepts operands and a start pulse;
  - loads the operands onto Z;
  - drives every read/write/unit-select control each cycle;
  - flags completion while the product is presented on datapath read port A.

Parameters:
- W, 16, operand width; operands are sign-extended to 32b on load.
- ITER, 32, shift-add iterations; 32 gives an exact 32b signed product.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low (rst==0 at posedge clk resets)
- start  in  1  begin a multiply; sampled only in IDLE or DONE
- op_a  in  W  multiplicand, sampled when start is accepted
- op_b  in  W  multiplier, sampled when start is accepted
- rd_enA  out  5  one-hot read select, port A (bit i = reg(i+1))
- rd_enB  out  5  one-hot read select, port B
- wr_en  out  5  one-hot write enable (0 = no write)
- ppgen_en  out  1  Z = ppgen(A,B)
- add_en  out  1  Z = A+B
- shift_en  out  1  Z = A shifted by B[4:0]
- left_right  out  1  1 = shift left, 0 = shift right (logical)
- ld_en  out  1  sequencer drives Z with ld_data
- ld_data  out  32  load value on Z
- busy  out  1  operation in progress
- done  out  1  product valid on datapath A

Behaviour:
- Register use: reg1 = multiplicand, reg2 = multiplier, reg3 = partial product, reg4 = accumulator, reg5 = shift amount.
- Output invariants, every cycle:
  - at most one of ppgen_en/add_en/shift_en/ld_en is high;
  - rd_enA and rd_enB are always exactly one-hot;
  - wr_en is zero or one-hot.
- Reset (rst==0):
  - state = IDLE; busy = 0, done = 0;
  - wr_en = 0, all Z enables = 0, left_right = 0, ld_data = 0;
  - rd_enA = rd_enB = 5'b00001;
  - iteration counter = 0; captured operands cleared.
  - Reset mid-operation aborts immediately.
- IDLE:
  - outputs as in reset;
  - start=1 → capture op_a/op_b, go to LD1.
- Load phase, one cycle each, ld_en=1, busy=1:
  - LD1: ld_data = sext(op_a), wr_en = 00001.
  - LD2: ld_data = sext(op_b), wr_en = 00010.
  - LD3: ld_data = 0, wr_en = 01000.
  - LD4: ld_data = 1, wr_en = 10000; counter = 0.
- Iteration loop (ITER passes), one cycle per step:
  - PP: A = reg1, B = reg2, ppgen_en, wr_en = 00100.
  - ACC: A = reg4, B = reg3, add_en, wr_en = 01000.
  - SHL: A = reg1, B = reg5, shift_en, left_right = 1, wr_en = 00001.
  - SHR: A = reg2, B = reg5, shift_en, left_right = 0, wr_en = 00010; counter++.
  - After SHR: if counter == ITER go to DONE, else go to PP.
- DONE:
  - done = 1, busy = 0; rd_enA = 01000 (product on A), rd_enB = 00001; wr_en = 0, Z enables = 0.
  - Held until start or reset.
  - start in DONE → capture operands, done drops next cycle, go to LD1 (back-to-back ops).
- Latency: start accepted at edge 0; done first high after 4 + 4·ITER edges (132 for ITER = 32).
- start while busy is ignored; captured operands do not change mid-operation.
- Arithmetic:
  - result = low 32b of sext(op_a) × sext(op_b) (two's complement);
  - the logical shifts are correct because the multiplier is sign-extended and fully consumed over 32 iterations.
- Counter width is clog2(ITER)+1; no wrap within an operation.

Test Plan:
- Reset, then op_a = 3, op_b = 5, pulse start → done high exactly 132 cycles after the start edge; A = 32'h0000_000F; busy low in DONE.
- op_a = -3 (16'hFFFD), op_b = 7 → A = 32'hFFFF_FFEB. op_a = 16'h8000, op_b = 16'h8000 → A = 32'h4000_0000.
- op_a = 16'h7FFF, op_b = 16'h7FFF → A = 32'h3FFF_0001. Start again from DONE with 0 × 1234 → A = 0 with no idle cycle between operations.
- Start pulsed at cycles 10 and 50 of a running op with different operands → ignored; original product returned at cycle 132.
- rst=0 at cycle 60 of an op → next edge state IDLE, wr_en = 0, all Z enables low, busy = done = 0; a fresh start then completes correctly.
- Assertion throughout all tests → Z enables mutually exclusive; rd_enA/rd_enB always one-hot; wr_en zero or one-hot.

Source files
------------

// File: rtl/mult_sequencer_if.sv
// Control bundle between the multiply sequencer and the shift-add datapath.
// Master drives datapath controls; slave is the datapath/requester view.
interface mult_sequencer_if #(
    parameter int W = 16
);
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [4:0]   rd_enA;
    logic [4:0]   rd_enB;
    logic [4:0]   wr_en;
    logic         ppgen_en;
    logic         add_en;
    logic         shift_en;
    logic         left_right;
    logic         ld_en;
    logic [31:0]  ld_data;
    logic         busy;
    logic         done;

    modport master (
        input  start, op_a, op_b,
        output rd_enA, rd_enB, wr_en,
        output ppgen_en, add_en, shift_en, left_right,
        output ld_en, ld_data, busy, done
    );

    modport slave (
        output start, op_a, op_b,
        input  rd_enA, rd_enB, wr_en,
        input  ppgen_en, add_en, shift_en, left_right,
        input  ld_en, ld_data, busy, done
    );
endinterface

// File: rtl/mult_sequencer.sv
// Sequencer for the 16b shift-add multiplier: loads operands onto Z, then
// runs ITER passes of pp/acc/shl/shr; controls are registered from next state.
module mult_sequencer #(
    parameter int W    = 16,
    parameter int ITER = 32
) (
    input  logic             clk,
    input  logic             rst,
    mult_sequencer_if.master bus
);
    localparam int CW = $clog2(ITER) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LD1, S_LD2, S_LD3, S_LD4,
        S_PP, S_ACC, S_SHL, S_SHR, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [4:0]     rd_a_q, rd_a_d;
    logic [4:0]     rd_b_q, rd_b_d;
    logic [4:0]     wr_q, wr_d;
    logic           pp_q, pp_d;
    logic           add_q, add_d;
    logic           sh_q, sh_d;
    logic           lr_q, lr_d;
    logic           ld_q, ld_d;
    logic [31:0]    ldd_q, ldd_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    state_d = S_LD1;
                end
            end
            S_LD1: state_d = S_LD2;
            S_LD2: state_d = S_LD3;
            S_LD3: begin
                state_d = S_LD4;
                cnt_d   = '0;
            end
            S_LD4: state_d = S_PP;
            S_PP:  state_d = S_ACC;
            S_ACC: state_d = S_SHL;
            S_SHL: begin
                state_d = S_SHR;
                cnt_d   = cnt_q + 1'b1;
            end
            S_SHR: begin
                if (cnt_q == CW'(ITER)) state_d = S_DONE;
                else                    state_d = S_PP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output controls are decoded from the next state so they register in
    // the same edge as the state they belong to.
    always_comb begin
        rd_a_d = 5'b00001;
        rd_b_d = 5'b00001;
        wr_d   = 5'b00000;
        pp_d   = 1'b0;
        add_d  = 1'b0;
        sh_d   = 1'b0;
        lr_d   = 1'b0;
        ld_d   = 1'b0;
        ldd_d  = 32'd0;
        busy_d = 1'b0;
        done_d = 1'b0;
        unique case (state_d)
            S_LD1: begin
                ld_d   = 1'b1;
                busy_d = 1'b1;
                ldd_d  = {{(32-W){a_d[W-1]}}, a_d};
                wr_d   = 5'b00001;
            end
            S_LD2: begin
                ld_d   = 1'b1;
                busy_d = 1'b1;
                ldd_d  = {{(32-W){b_d[W-1]}}, b_d};
                wr_d   = 5'b00010;
            end
            S_LD3: begin
                ld_d   = 1'b1;
                busy_d = 1'b1;
                wr_d   = 5'b01000;
            end
            S_LD4: begin
                ld_d   = 1'b1;
                busy_d = 1'b1;
                ldd_d  = 32'd1;
                wr_d   = 5'b10000;
            end
            S_PP: begin
                busy_d = 1'b1;
                rd_a_d = 5'b00001;
                rd_b_d = 5'b00010;
                pp_d   = 1'b1;
                wr_d   = 5'b00100;
            end
            S_ACC: begin
                busy_d = 1'b1;
                rd_a_d = 5'b01000;
                rd_b_d = 5'b00100;
                add_d  = 1'b1;
                wr_d   = 5'b01000;
            end
            S_SHL: begin
                busy_d = 1'b1;
                rd_a_d = 5'b00001;
                rd_b_d = 5'b10000;
                sh_d   = 1'b1;
                lr_d   = 1'b1;
                wr_d   = 5'b00001;
            end
            S_SHR: begin
                busy_d = 1'b1;
                rd_a_d = 5'b00010;
                rd_b_d = 5'b10000;
                sh_d   = 1'b1;
                wr_d   = 5'b00010;
            end
            S_DONE: begin
                done_d = 1'b1;
                rd_a_d = 5'b01000;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_a_q  <= 5'b00001;
            rd_b_q  <= 5'b00001;
            wr_q    <= 5'b00000;
            pp_q    <= 1'b0;
            add_q   <= 1'b0;
            sh_q    <= 1'b0;
            lr_q    <= 1'b0;
            ld_q    <= 1'b0;
            ldd_q   <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            wr_q    <= wr_d;
            pp_q    <= pp_d;
            add_q   <= add_d;
            sh_q    <= sh_d;
            lr_q    <= lr_d;
            ld_q    <= ld_d;
            ldd_q   <= ldd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.rd_enA     = rd_a_q;
    assign bus.rd_enB     = rd_b_q;
    assign bus.wr_en      = wr_q;
    assign bus.ppgen_en   = pp_q;
    assign bus.add_en     = add_q;
    assign bus.shift_en   = sh_q;
    assign bus.left_right = lr_q;
    assign bus.ld_en      = ld_q;
    assign bus.ld_data    = ldd_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule
